serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/fullsubtractor_1c.sv | 21 ++
 rtl/serial_subtractor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//
// Contents:
//   DefaultWidth - default operand/result width in bits
//   state_e      - controller states (idle, shifting, result held)
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/fullsubtractor_1c.sv
// One-bit full subtractor, purely combinational.
//
// Ports:
//   a     - minuend bit
//   b     - subtrahend bit
//   b_in  - borrow from the next-lower bit
//   b_out - borrow into the next-higher bit
//   diff  - difference bit (a - b - b_in)
module fullsubtractor_1c (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic b_out,
  output logic diff
);

  assign diff  = a ^ b ^ b_in;
  // Borrow when b exceeds a, or when they are equal and a borrow comes in.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes DIFF = A - B - B_IN one bit per clock, LSB first,
// through a single full-subtractor stage, with valid/ready handshakes on both sides.
//
// Parameters:
//   WIDTH     - operand and result width in bits (2..16)
//
// Ports:
//   CLK       - clock, rising edge
//   RST       - synchronous active-high reset
//   IN_VALID  - operands presented
//   IN_READY  - block idle and able to accept operands
//   A, B      - minuend, subtrahend
//   B_IN      - borrow-in
//   OUT_VALID - result held on DIFF/B_OUT/OVF
//   OUT_READY - consumer accepts the result
//   DIFF      - difference, mod 2^WIDTH
//   B_OUT     - borrow-out (unsigned A < B + B_IN)
//   OVF       - signed-overflow flag
//
// Configuration:
//   SERIAL_SUB_OVF_EN - when defined, OVF is computed and registered with DIFF;
//                       otherwise OVF is tied to 0 and no overflow logic exists.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DIFF,
  output logic             B_OUT,
  output logic             OVF
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  // Counter value once every bit has been processed; one more SHIFT edge then
  // commits the result and enters DONE.
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;

  logic             fs_b_out;
  logic             fs_diff;

  fullsubtractor_1c u_fs (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .b_in  (borrow_q),
    .b_out (fs_b_out),
    .diff  (fs_diff)
  );

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    res_d    = res_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          a_d      = A;
          b_d      = B;
          borrow_d = B_IN;
          cnt_d    = '0;
          res_d    = '0;
          state_d  = StShift;
        end
      end

      StShift: begin
        if (cnt_q != CntLast) begin
          // Operands rotate rather than shift so their MSBs are back in place
          // after WIDTH bits, where the overflow term needs them.
          a_d      = {a_q[0], a_q[WIDTH-1:1]};
          b_d      = {b_q[0], b_q[WIDTH-1:1]};
          borrow_d = fs_b_out;
          res_d    = {fs_diff, res_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CntW'(1);
        end else begin
          diff_d  = res_q;
          b_out_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);
`endif
          state_d = StDone;
        end
      end

      StDone: begin
        if (OUT_READY) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

  assign IN_READY  = (state_q == StIdle);
  assign OUT_VALID = (state_q == StDone);
  assign DIFF      = diff_q;
  assign B_OUT     = b_out_q;

endmodule
